// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// master: the side that supplies operands and consumes results.
// slave:  the adder itself.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor. Operands are latched once, then
// streamed one nibble per cycle through a single 4-bit CLA slice whose
// carry-out is registered and fed back as the next nibble's carry-in.
// Optional feature macro: NIBBLE_ADDER_SUB_EN (subtraction support). When it
// is undefined, the sub input is ignored and the block only adds.

// 4-bit carry-lookahead slice: all carries computed from generate/propagate.
module nibble_serial_adder_cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = x & y;
  assign p = x ^ y;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s  = p ^ c[3:0];
  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_adder_if.slave   bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c_nib;

`ifdef NIBBLE_ADDER_SUB_EN
  // Subtraction as a + ~b + 1: invert b and start the chain with carry 1.
  assign b_in     = bus.sub ? ~bus.b : bus.b;
  assign carry_in = bus.sub;
`else
  // Add-only build: sub is accepted on the port but has no effect.
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_in       = bus.b;
  assign carry_in   = 1'b0;
`endif

  // Select the idx-th nibble of each latched operand for the shared slice.
  assign a_nib = 4'(a_lat >> {idx, 2'b00});
  assign b_nib = 4'(b_eff >> {idx, 2'b00});

  nibble_serial_adder_cla4 u_slice (
    .x  (a_nib),
    .y  (b_nib),
    .ci (carry),
    .s  (s_nib),
    .co (c_nib)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; handshake outputs decode from state only.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, nibble-serial accumulation and final flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_lat <= bus.a;
            b_eff <= b_in;
            carry <= carry_in;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) sum_r[4*i +: 4] <= s_nib;
          end
          carry <= c_nib;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_r <= c_nib;
            // Like-signed operands producing an opposite-signed result.
            ovf_r  <= (a_lat[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (s_nib[3] != a_lat[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
endmodule
